sys_bridge: RTL and testbench

//  CPU-side initiator for the peripheral bus that device slaves (e.g. the timer) sit on.

---
 rtl/bridge_pkg.sv | 14 +
 rtl/irq_ctrl.sv | 63 ++++++
 rtl/sys_bridge.sv | 164 ++++++++++++++++
 tb/tb_sys_bridge.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bus bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned DEV_SPAN  = 16;
  localparam int unsigned REG_IMASK = 0;
  localparam int unsigned REG_IPEND = 4;

endpackage

// File: rtl/irq_ctrl.sv
// Interrupt mask/pending registers and the CPU interrupt request.
// Build option BRIDGE_IRQ_EDGE_EN: sticky rising-edge pending bits with W1C; otherwise level mode.
module irq_ctrl #(
  parameter int unsigned NDEV = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NDEV-1:0] irq_i,
  input  logic            mask_we_i,
  input  logic            pend_w1c_i,
  input  logic [NDEV-1:0] wdata_i,
  output logic [NDEV-1:0] imask_o,
  output logic [NDEV-1:0] ipend_o,
  output logic            int_o
);

  logic [NDEV-1:0] r_imask;
  logic [NDEV-1:0] r_ipend;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_imask <= '0;
    end else if (mask_we_i) begin
      r_imask <= wdata_i;
    end
  end

`ifdef BRIDGE_IRQ_EDGE_EN
  logic [NDEV-1:0] r_irq_prev;
  logic [NDEV-1:0] w_rise;
  logic [NDEV-1:0] w_clr;

  assign w_rise = irq_i & ~r_irq_prev;
  assign w_clr  = pend_w1c_i ? wdata_i : '0;

  // Clear is applied before set so a coincident new edge is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_prev <= '0;
      r_ipend    <= '0;
    end else begin
      r_irq_prev <= irq_i;
      r_ipend    <= (r_ipend & ~w_clr) | w_rise;
    end
  end
`else
  logic w_unused_w1c;
  assign w_unused_w1c = pend_w1c_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ipend <= '0;
    end else begin
      r_ipend <= irq_i;
    end
  end
`endif

  assign imask_o = r_imask;
  assign ipend_o = r_ipend;
  assign int_o   = |(r_ipend & r_imask);

endmodule

// File: rtl/sys_bridge.sv
// CPU-side peripheral bus initiator: address decode, 3-state access FSM, IRQ collection.
// Build option BRIDGE_IRQ_EDGE_EN selects edge-triggered pending bits (see irq_ctrl).
module sys_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned NDEV     = 2,
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
  parameter logic [31:0] REG_OFS  = 32'h0000_0080
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pr_req_i,
  input  logic                 pr_we_i,
  input  logic [31:0]          pr_addr_i,
  input  logic [31:0]          pr_wd_i,
  output logic [31:0]          pr_rd_o,
  output logic                 pr_ack_o,
  output logic                 pr_err_o,
  output logic [NDEV-1:0]      dev_sel_o,
  output logic                 dev_we_o,
  output logic [1:0]           dev_add_o,
  output logic [31:0]          dev_dat_o,
  input  logic [NDEV*32-1:0]   dev_dat_i,
  input  logic [NDEV-1:0]      dev_irq_i,
  output logic                 int_o
);

  localparam int          SPAN_LSB   = $clog2(DEV_SPAN) - 2;
  localparam logic [31:0] IMASK_ADDR = REG_OFS + REG_IMASK;
  localparam logic [31:0] IPEND_ADDR = REG_OFS + REG_IPEND;

  state_t          r_state;
  state_t          w_state_next;
  logic [29:0]     r_addr;
  logic            r_we;
  logic [31:0]     r_wd;
  logic [31:0]     r_rd;
  logic            r_err;

  logic [29:0]     w_ofs;
  logic [NDEV-1:0] w_hit_dev;
  logic            w_hit_any;
  logic            w_hit_imask;
  logic            w_hit_ipend;
  logic            w_unmapped;
  logic [31:0]     w_dev_rd;
  logic [31:0]     w_rd_next;
  logic [NDEV-1:0] w_imask;
  logic [NDEV-1:0] w_ipend;
  logic            w_mask_we;
  logic            w_pend_w1c;
  logic            w_unused_addr;

  assign w_unused_addr = ^pr_addr_i[1:0];

  // Word offset into the device window; addresses below the base wrap high and miss.
  assign w_ofs = r_addr - DEV_BASE[31:2];

  for (genvar gi = 0; gi < NDEV; gi++) begin : g_dec
    assign w_hit_dev[gi] = ((w_ofs >> SPAN_LSB) == 30'(gi));
  end

  assign w_hit_any   = |w_hit_dev;
  assign w_hit_imask = (w_ofs == IMASK_ADDR[31:2]);
  assign w_hit_ipend = (w_ofs == IPEND_ADDR[31:2]);
  assign w_unmapped  = ~(w_hit_any | w_hit_imask | w_hit_ipend);

  always_comb begin
    w_dev_rd = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (w_hit_dev[k]) begin
        w_dev_rd = w_dev_rd | dev_dat_i[k*32 +: 32];
      end
    end
  end

  always_comb begin
    w_rd_next = '0;
    if (w_hit_any) begin
      w_rd_next = w_dev_rd;
    end else if (w_hit_imask) begin
      w_rd_next = 32'(w_imask);
    end else if (w_hit_ipend) begin
      w_rd_next = 32'(w_ipend);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (pr_req_i) w_state_next = ACCESS;
      ACCESS:  w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    dev_sel_o  = '0;
    dev_we_o   = 1'b0;
    pr_ack_o   = 1'b0;
    pr_err_o   = 1'b0;
    w_mask_we  = 1'b0;
    w_pend_w1c = 1'b0;
    case (r_state)
      ACCESS: begin
        dev_sel_o  = w_hit_dev;
        dev_we_o   = r_we & w_hit_any;
        w_mask_we  = r_we & w_hit_imask;
        w_pend_w1c = r_we & w_hit_ipend;
      end
      RESP: begin
        pr_ack_o = 1'b1;
        pr_err_o = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_we   <= 1'b0;
      r_wd   <= '0;
      r_rd   <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == IDLE && pr_req_i) begin
        r_addr <= pr_addr_i[31:2];
        r_we   <= pr_we_i;
        r_wd   <= pr_wd_i;
      end
      if (r_state == ACCESS) begin
        r_rd  <= w_rd_next;
        r_err <= w_unmapped;
      end
    end
  end

  assign pr_rd_o   = r_rd;
  assign dev_add_o = r_addr[1:0];
  assign dev_dat_o = r_wd;

  irq_ctrl #(.NDEV(NDEV)) u_irq_ctrl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .irq_i      (dev_irq_i),
    .mask_we_i  (w_mask_we),
    .pend_w1c_i (w_pend_w1c),
    .wdata_i    (r_wd[NDEV-1:0]),
    .imask_o    (w_imask),
    .ipend_o    (w_ipend),
    .int_o      (int_o)
  );

endmodule

// File: tb/tb_sys_bridge.sv
// Self-checking bench for sys_bridge: directed scenarios plus randomized accesses
// against a transaction-level model of decode, bridge registers and interrupt pending.
module tb_sys_bridge;

  localparam int          NDEV = 2;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 pr_req_i;
  logic                 pr_we_i;
  logic [31:0]          pr_addr_i;
  logic [31:0]          pr_wd_i;
  logic [31:0]          pr_rd_o;
  logic                 pr_ack_o;
  logic                 pr_err_o;
  logic [NDEV-1:0]      dev_sel_o;
  logic                 dev_we_o;
  logic [1:0]           dev_add_o;
  logic [31:0]          dev_dat_o;
  logic [NDEV*32-1:0]   dev_dat_i;
  logic [NDEV-1:0]      dev_irq_i;
  logic                 int_o;

  always #5 clk_i = ~clk_i;

  sys_bridge #(.NDEV(NDEV)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pr_req_i  (pr_req_i),
    .pr_we_i   (pr_we_i),
    .pr_addr_i (pr_addr_i),
    .pr_wd_i   (pr_wd_i),
    .pr_rd_o   (pr_rd_o),
    .pr_ack_o  (pr_ack_o),
    .pr_err_o  (pr_err_o),
    .dev_sel_o (dev_sel_o),
    .dev_we_o  (dev_we_o),
    .dev_add_o (dev_add_o),
    .dev_dat_o (dev_dat_o),
    .dev_dat_i (dev_dat_i),
    .dev_irq_i (dev_irq_i),
    .int_o     (int_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state for the bridge's own registers
  logic [NDEV-1:0] m_imask, m_ipend, m_prev, m_wdat;
  logic            m_wr_mask = 1'b0;
  logic            m_wr_w1c  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then check int_o.
  task automatic step();
    @(posedge clk_i);
    if (rst_i) begin
      m_imask = '0;
      m_ipend = '0;
      m_prev  = '0;
    end else begin
      if (m_wr_mask) m_imask = m_wdat;
`ifdef BRIDGE_IRQ_EDGE_EN
      m_ipend = (m_ipend & ~(m_wr_w1c ? m_wdat : '0)) | (dev_irq_i & ~m_prev);
      m_prev  = dev_irq_i;
`else
      m_ipend = dev_irq_i;
`endif
    end
    #1;
    check("int_o", 32'(int_o), 32'(|(m_ipend & m_imask)));
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [NDEV-1:0] irq_mid, input string tag);
    logic [31:0] ofs;
    int          dev;
    logic        is_mask, is_pend, exp_err;
    logic [31:0] exp_rd, exp_sel;
    ofs     = addr - BASE;
    dev     = (ofs < 32'(16 * NDEV)) ? int'(ofs >> 4) : -1;
    is_mask = (ofs[31:2] == 30'h20);
    is_pend = (ofs[31:2] == 30'h21);
    exp_err = (dev < 0) && !is_mask && !is_pend;
    exp_sel = (dev >= 0) ? (32'd1 << dev) : 32'd0;

    pr_req_i = 1'b1; pr_we_i = we; pr_addr_i = addr; pr_wd_i = wd;
    step();
    // Scramble the request bus: the bridge must work from its own latched copy.
    pr_req_i = 1'b0; pr_we_i = 1'($urandom); pr_addr_i = $urandom; pr_wd_i = $urandom;
    check({tag, ".sel"}, exp_sel, 32'(dev_sel_o));
    check({tag, ".dwe"}, 32'(dev_we_o), 32'(we && dev >= 0));
    check({tag, ".add"}, 32'(dev_add_o), 32'(addr[3:2]));
    check({tag, ".dat"}, dev_dat_o, wd);
    check({tag, ".ack_early"}, 32'(pr_ack_o), 32'd0);
    if (dev >= 0)     exp_rd = dev_dat_i[dev*32 +: 32];
    else if (is_mask) exp_rd = 32'(m_imask);
    else if (is_pend) exp_rd = 32'(m_ipend);
    else              exp_rd = 32'd0;
    m_wr_mask = we && is_mask;
    m_wr_w1c  = we && is_pend;
    m_wdat    = wd[NDEV-1:0];
    dev_irq_i = irq_mid;
    step();
    m_wr_mask = 1'b0;
    m_wr_w1c  = 1'b0;
    check({tag, ".ack"}, 32'(pr_ack_o), 32'd1);
    check({tag, ".err"}, 32'(pr_err_o), 32'(exp_err));
    if (!we) check({tag, ".rd"}, pr_rd_o, exp_rd);
    check({tag, ".sel_resp"}, 32'(dev_sel_o), 32'd0);
    step();
    check({tag, ".ack_end"}, 32'(pr_ack_o), 32'd0);
    $display("%s: we=%0d addr=%h wd=%h rd=%h err=%0d", tag, we, addr, wd, pr_rd_o, exp_err);
  endtask

  initial begin
    logic [31:0] a;
    logic [NDEV-1:0] irq;
    rst_i = 1'b1; pr_req_i = 1'b0; pr_we_i = 1'b0; pr_addr_i = '0; pr_wd_i = '0;
    dev_dat_i = '0; dev_irq_i = '0;
    step();
    step();
    check("rst.sel", 32'(dev_sel_o), 32'd0);
    check("rst.ack", 32'(pr_ack_o), 32'd0);
    check("rst.rd", pr_rd_o, 32'd0);
    check("rst.dat", dev_dat_o, 32'd0);
    rst_i = 1'b0;
    step();

    dev_dat_i = {32'hCAFE_0001, 32'h1234_5678};
    access(1'b0, 32'h7F18, 32'h0, dev_irq_i, "rd_dev1");
    check("rd_dev1.const", pr_rd_o, 32'hCAFE_0001);
    access(1'b1, 32'h7F04, 32'h64, dev_irq_i, "wr_dev0");
    access(1'b0, 32'h7F40, 32'h0, dev_irq_i, "unmapped");

    access(1'b1, 32'h7F80, 32'h1, dev_irq_i, "wr_imask");
    access(1'b0, 32'h7F80, 32'h0, dev_irq_i, "rd_imask");
    dev_irq_i = 2'b01;
    step();
    step();
    check("irq.int_const", 32'(int_o), 32'd1);
    access(1'b0, 32'h7F84, 32'h0, dev_irq_i, "rd_ipend");
    access(1'b1, 32'h7F84, 32'h1, dev_irq_i, "w1c0");
    repeat (3) step();
    access(1'b0, 32'h7F84, 32'h0, dev_irq_i, "rd_ipend2");
    // New rising edge on line 1 exactly on the cycle its W1C takes effect
    access(1'b1, 32'h7F84, 32'h2, 2'b11, "w1c_vs_set");
    access(1'b0, 32'h7F84, 32'h0, dev_irq_i, "rd_ipend3");
    dev_irq_i = 2'b00;
    step();
    access(1'b0, 32'h7F84, 32'h0, dev_irq_i, "rd_ipend4");

    // Reset while in ACCESS: no ack, everything back to zero
    pr_req_i = 1'b1; pr_we_i = 1'b1; pr_addr_i = 32'h7F04; pr_wd_i = 32'hDEAD_BEEF;
    step();
    pr_req_i = 1'b0;
    check("abort.sel_pre", 32'(dev_sel_o), 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("abort.sel", 32'(dev_sel_o), 32'd0);
    check("abort.we", 32'(dev_we_o), 32'd0);
    check("abort.ack", 32'(pr_ack_o), 32'd0);
    check("abort.err", 32'(pr_err_o), 32'd0);
    check("abort.rd", pr_rd_o, 32'd0);
    check("abort.dat", dev_dat_o, 32'd0);
    check("abort.add", 32'(dev_add_o), 32'd0);
    step();
    check("abort.no_ack", 32'(pr_ack_o), 32'd0);
    access(1'b0, 32'h7F14, 32'h0, dev_irq_i, "post_abort");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1: a = BASE + 32'(16 * $urandom_range(0, NDEV - 1)) + 32'(4 * $urandom_range(0, 3));
        2:    a = BASE + 32'h80 + 32'(4 * $urandom_range(0, 1));
        3:    a = BASE + 32'h20 + 32'(4 * $urandom_range(0, 23));
        default: a = $urandom;
      endcase
      a = a | 32'($urandom_range(0, 3));
      dev_dat_i = {$urandom, $urandom};
      dev_irq_i = NDEV'($urandom);
      irq = NDEV'($urandom);
      repeat ($urandom_range(0, 2)) step();
      access(1'($urandom), a, $urandom, irq, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
